// File: rtl/simple_ctrl.sv
// simple_ctrl: FETCH/EXEC/WB instruction sequencer for the SIMPLE 16-bit datapath.
// Define SIMPLE_CTRL_STEP_EN to add the `step` input and a PAUSE state after each WB.
module simple_ctrl #(
   parameter int PC_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
`ifdef SIMPLE_CTRL_STEP_EN
   input  logic            step,
`endif
   output logic [PC_W-1:0] pc,
   input  logic [15:0]     instr,
   input  logic [3:0]      szcv,
   output logic [2:0]      AR_idx,
   output logic [2:0]      BR_idx,
   output logic [2:0]      wr_idx,
   output logic            rdAR_en,
   output logic            rdBR_en,
   output logic            wr_en,
   output logic            wrclk,
   output logic            alu_en,
   output logic            sft_en,
   output logic            immd_en,
   output logic            in_en,
   output logic            out_en,
   output logic [3:0]      op3,
   output logic [7:0]      immd,
   output logic            halted,
   output logic            illegal
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4
`ifdef SIMPLE_CTRL_STEP_EN
      , S_PAUSE = 3'd5
`endif
   } state_t;

   typedef struct packed {
      logic [2:0] ar_idx;
      logic [2:0] br_idx;
      logic [2:0] wr_idx;
      logic       rd_ar_en;
      logic       rd_br_en;
      logic       wr_en;
      logic       alu_en;
      logic       sft_en;
      logic       immd_en;
      logic       in_en;
      logic       out_en;
      logic [3:0] op3;
      logic [7:0] immd;
      logic       flag_ld;
      logic       is_hlt;
      logic       is_illegal;
   } ctl_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [3:0]      flags_q, flags_d;
   ctl_t            ctl_q, ctl_d;
   logic            wrclk_q, wrclk_d;
   logic            out_en_q, out_en_d;
   logic            illegal_q, illegal_d;
   logic            halted_q, halted_d;

   ctl_t            dec;
   logic [1:0]      i_op1;
   logic [2:0]      i_rs;
   logic [2:0]      i_rd;
   logic [3:0]      i_op3;

   logic            br_taken;
   logic [PC_W-1:0] br_off;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_wb;
   logic            flag_s;
   logic            flag_z;
   logic            flag_v;
   logic            unused_flag_c;

   assign i_op1 = instr[15:14];
   assign i_rs  = instr[13:11];
   assign i_rd  = instr[10:8];
   assign i_op3 = instr[7:4];

   // Decode straight from the instruction bus so controls are ready on entry to EXEC.
   always_comb begin
      dec = '0;
      case (i_op1)
         2'b11: begin
            if (i_op3 <= 4'd6) begin
               dec.ar_idx   = i_rd;
               dec.br_idx   = i_rs;
               dec.rd_ar_en = 1'b1;
               dec.rd_br_en = 1'b1;
               dec.alu_en   = 1'b1;
               dec.op3      = i_op3;
               dec.wr_idx   = i_rd;
               dec.wr_en    = (i_op3 != 4'd5);
               dec.flag_ld  = 1'b1;
            end else if (i_op3 >= 4'd8 && i_op3 <= 4'd11) begin
               dec.br_idx   = i_rd;
               dec.rd_br_en = 1'b1;
               dec.sft_en   = 1'b1;
               dec.op3      = i_op3;
               dec.immd     = {4'h0, instr[3:0]};
               dec.wr_idx   = i_rd;
               dec.wr_en    = 1'b1;
               dec.flag_ld  = 1'b1;
            end else if (i_op3 == 4'd12) begin
               dec.in_en    = 1'b1;
               dec.wr_idx   = i_rd;
               dec.wr_en    = 1'b1;
            end else if (i_op3 == 4'd13) begin
               dec.br_idx   = i_rs;
               dec.rd_br_en = 1'b1;
               dec.out_en   = 1'b1;
            end else if (i_op3 == 4'd15) begin
               dec.is_hlt   = 1'b1;
            end else begin
               dec.is_illegal = 1'b1;
            end
         end
         2'b10: begin
            if (i_rs == 3'b000) begin
               dec.immd_en  = 1'b1;
               dec.immd     = instr[7:0];
               dec.wr_idx   = i_rd;
               dec.wr_en    = 1'b1;
            end else if (i_rs == 3'b100 || (i_rs == 3'b111 && !i_rd[2])) begin
               // Branches drive no datapath controls; the target is resolved in WB.
               dec.is_illegal = 1'b0;
            end else begin
               dec.is_illegal = 1'b1;
            end
         end
         default: dec.is_illegal = 1'b1;
      endcase
   end

   assign flag_s        = flags_q[3];
   assign flag_z        = flags_q[2];
   assign flag_v        = flags_q[0];
   assign unused_flag_c = flags_q[1];

   always_comb begin
      br_taken = 1'b0;
      if (ir_q[15:14] == 2'b10) begin
         if (ir_q[13:11] == 3'b100) begin
            br_taken = 1'b1;
         end else if (ir_q[13:11] == 3'b111) begin
            case (ir_q[10:8])
               3'b000:  br_taken = flag_z;
               3'b001:  br_taken = flag_s ^ flag_v;
               3'b010:  br_taken = flag_z | (flag_s ^ flag_v);
               3'b011:  br_taken = ~flag_z;
               default: br_taken = 1'b0;
            endcase
         end
      end
   end

   assign br_off = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};
   assign pc_inc = pc_q + PC_W'(1);
   assign pc_wb  = ctl_q.is_hlt ? pc_q : (br_taken ? pc_inc + br_off : pc_inc);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      flags_d   = flags_q;
      ctl_d     = ctl_q;
      wrclk_d   = 1'b0;
      out_en_d  = 1'b0;
      illegal_d = 1'b0;
      halted_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d    = instr;
            ctl_d   = dec;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (ctl_q.flag_ld) flags_d = szcv;
            wrclk_d   = 1'b1;
            out_en_d  = ctl_q.out_en;
            illegal_d = ctl_q.is_illegal;
            state_d   = S_WB;
         end
         S_WB: begin
            ctl_d = '0;
            pc_d  = pc_wb;
            if (ctl_q.is_hlt) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else begin
`ifdef SIMPLE_CTRL_STEP_EN
               state_d = S_PAUSE;
`else
               state_d = S_FETCH;
`endif
            end
         end
         S_HALT: begin
            halted_d = 1'b1;
         end
`ifdef SIMPLE_CTRL_STEP_EN
         S_PAUSE: begin
            if (step) state_d = S_FETCH;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         flags_q   <= '0;
         ctl_q     <= '0;
         wrclk_q   <= 1'b0;
         out_en_q  <= 1'b0;
         illegal_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         flags_q   <= flags_d;
         ctl_q     <= ctl_d;
         wrclk_q   <= wrclk_d;
         out_en_q  <= out_en_d;
         illegal_q <= illegal_d;
         halted_q  <= halted_d;
      end
   end

   assign pc      = pc_q;
   assign AR_idx  = ctl_q.ar_idx;
   assign BR_idx  = ctl_q.br_idx;
   assign wr_idx  = ctl_q.wr_idx;
   assign rdAR_en = ctl_q.rd_ar_en;
   assign rdBR_en = ctl_q.rd_br_en;
   assign wr_en   = ctl_q.wr_en;
   assign alu_en  = ctl_q.alu_en;
   assign sft_en  = ctl_q.sft_en;
   assign immd_en = ctl_q.immd_en;
   assign in_en   = ctl_q.in_en;
   assign op3     = ctl_q.op3;
   assign immd    = ctl_q.immd;
   assign wrclk   = wrclk_q;
   assign out_en  = out_en_q;
   assign illegal = illegal_q;
   assign halted  = halted_q;

endmodule

// File: tb/tb_simple_ctrl.sv
// Self-checking bench for simple_ctrl: constant vector table, directed corner sequences,
// and random programs checked against an instruction-level reference model.
module tb_simple_ctrl;

   logic        clk;
   logic        rst;
   logic        run;
   logic [15:0] pc;
   logic [15:0] instr;
   logic [3:0]  szcv;
   logic [2:0]  AR_idx, BR_idx, wr_idx;
   logic        rdAR_en, rdBR_en, wr_en, wrclk;
   logic        alu_en, sft_en, immd_en, in_en, out_en;
   logic [3:0]  op3;
   logic [7:0]  immd;
   logic        halted, illegal;
`ifdef SIMPLE_CTRL_STEP_EN
   logic        step;
`endif

   logic [15:0] mem [0:65535];
   assign instr = mem[pc];

   simple_ctrl #(.PC_W(16)) dut (
      .clk(clk), .rst(rst), .run(run),
`ifdef SIMPLE_CTRL_STEP_EN
      .step(step),
`endif
      .pc(pc), .instr(instr), .szcv(szcv),
      .AR_idx(AR_idx), .BR_idx(BR_idx), .wr_idx(wr_idx),
      .rdAR_en(rdAR_en), .rdBR_en(rdBR_en), .wr_en(wr_en), .wrclk(wrclk),
      .alu_en(alu_en), .sft_en(sft_en), .immd_en(immd_en), .in_en(in_en),
      .out_en(out_en), .op3(op3), .immd(immd), .halted(halted), .illegal(illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [2:0] ar;
      logic [2:0] br;
      logic [2:0] wr;
      logic       rd_ar;
      logic       rd_br;
      logic       wr_en;
      logic       wrclk;
      logic       alu;
      logic       sft;
      logic       immd_en;
      logic       in_en;
      logic       out_en;
      logic [3:0] op3;
      logic [7:0] immd;
      logic       halted;
      logic       illegal;
   } obs_t;

   // en bits: [7]rdAR [6]rdBR [5]wr_en [4]alu [3]sft [2]immd_en [1]in_en [0]out_en(WB)
   typedef struct {
      logic [15:0] iw;
      logic [2:0]  ar;
      logic [2:0]  br;
      logic [2:0]  wr;
      logic [7:0]  en;
      logic [3:0]  op3;
      logic [7:0]  immd;
      logic        ill;
   } vec_t;

   localparam int NV = 12;
   vec_t tv [NV];

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] m_pc;
   logic [3:0]  m_flags;
   obs_t        zo;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (pc=%h)", name, act, exp, pc);
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.ar = AR_idx;   o.br = BR_idx;   o.wr = wr_idx;
      o.rd_ar = rdAR_en; o.rd_br = rdBR_en; o.wr_en = wr_en; o.wrclk = wrclk;
      o.alu = alu_en;  o.sft = sft_en;  o.immd_en = immd_en; o.in_en = in_en;
      o.out_en = out_en; o.op3 = op3;   o.immd = immd;
      o.halted = halted; o.illegal = illegal;
      return o;
   endfunction

   // ---------------- reference model ----------------
   function automatic bit m_legal(input logic [15:0] iw);
      logic [3:0] f;
      f = iw[7:4];
      if (iw[15:14] == 2'b11) return !(f == 4'd7 || f == 4'd14);
      if (iw[15:14] == 2'b10)
         return (iw[13:11] == 3'b000) || (iw[13:11] == 3'b100) ||
                (iw[13:11] == 3'b111 && iw[10] == 1'b0);
      return 1'b0;
   endfunction

   function automatic bit m_is_hlt(input logic [15:0] iw);
      return iw[15:14] == 2'b11 && iw[7:4] == 4'hF;
   endfunction

   function automatic bit m_sets_flags(input logic [15:0] iw);
      return iw[15:14] == 2'b11 && (iw[7:4] <= 4'd6 || (iw[7:4] >= 4'd8 && iw[7:4] <= 4'd11));
   endfunction

   // phase: 1 = EXEC, 2 = WB, 3 = HALT
   function automatic obs_t m_ctl(input logic [15:0] iw, input int phase);
      obs_t o;
      logic [2:0] rs, rd;
      logic [3:0] f;
      o = '0; rs = iw[13:11]; rd = iw[10:8]; f = iw[7:4];
      if (phase == 3) begin
         o.halted = 1'b1;
         return o;
      end
      if (m_legal(iw)) begin
         if (iw[15:14] == 2'b11) begin
            if (f <= 4'd6) begin
               o.ar = rd; o.br = rs; o.rd_ar = 1'b1; o.rd_br = 1'b1; o.alu = 1'b1;
               o.op3 = f; o.wr = rd; o.wr_en = (f != 4'd5);
            end else if (f >= 4'd8 && f <= 4'd11) begin
               o.br = rd; o.rd_br = 1'b1; o.sft = 1'b1; o.op3 = f;
               o.immd = {4'h0, iw[3:0]}; o.wr = rd; o.wr_en = 1'b1;
            end else if (f == 4'd12) begin
               o.in_en = 1'b1; o.wr = rd; o.wr_en = 1'b1;
            end else if (f == 4'd13) begin
               o.br = rs; o.rd_br = 1'b1; o.out_en = (phase == 2);
            end
         end else if (rs == 3'b000) begin
            o.immd_en = 1'b1; o.immd = iw[7:0]; o.wr = rd; o.wr_en = 1'b1;
         end
      end else if (phase == 2) begin
         o.illegal = 1'b1;
      end
      if (phase == 2) o.wrclk = 1'b1;
      return o;
   endfunction

   function automatic logic [15:0] m_next_pc(input logic [15:0] iw, input logic [15:0] cur,
                                             input logic [3:0] fl);
      int  d;
      bit  s, z, v, take;
      s = fl[3]; z = fl[2]; v = fl[0];
      d = $signed(iw[7:0]);
      take = 1'b0;
      if (m_is_hlt(iw)) return cur;
      if (m_legal(iw) && iw[15:14] == 2'b10) begin
         if (iw[13:11] == 3'b100) take = 1'b1;
         if (iw[13:11] == 3'b111) begin
            case (iw[9:8])
               2'd0: take = z;
               2'd1: take = s ^ v;
               2'd2: take = z | (s ^ v);
               default: take = !z;
            endcase
         end
      end
      if (take) return 16'((int'(cur) + 1 + d) & 32'hFFFF);
      return 16'((int'(cur) + 1) & 32'hFFFF);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic pause_pass();
`ifdef SIMPLE_CTRL_STEP_EN
      check("pause_ctl", sample(), zo);
      tick();
`endif
   endtask

   task automatic reset_run();
      rst = 1'b1; run = 1'b0;
      tick(); tick();
      rst = 1'b0; run = 1'b1;
      tick();
      run = 1'b0;
      m_pc = 16'h0; m_flags = 4'h0;
   endtask

   // Enter in FETCH, leave in the next FETCH (or HALT when was_hlt).
   task automatic run_instr(input logic [3:0] flags_in, output bit was_hlt);
      logic [15:0] iw;
      iw = mem[m_pc];
      check("fetch_pc", pc, m_pc);
      check("fetch_ctl", sample(), zo);
      szcv = 4'($urandom);
      run  = 1'($urandom_range(0, 1));
      tick();
      check("exec_ctl", sample(), m_ctl(iw, 1));
      szcv = flags_in;
      tick();
      check("wb_ctl", sample(), m_ctl(iw, 2));
      check("wb_pc", pc, m_pc);
      szcv = ~flags_in;
      m_pc = m_next_pc(iw, m_pc, m_flags);
      if (m_sets_flags(iw)) m_flags = flags_in;
      was_hlt = m_is_hlt(iw);
      tick();
      run = 1'b0;
      if (was_hlt) begin
         check("halt_ctl", sample(), m_ctl(iw, 3));
         check("halt_pc", pc, m_pc);
      end else begin
         pause_pass();
      end
   endtask

   function automatic logic [15:0] gen_instr();
      logic [15:0] iw;
      iw = 16'($urandom);
      case ($urandom_range(0, 3))
         0: begin
            iw[15:14] = 2'b10;
            case ($urandom_range(0, 2))
               0: iw[13:11] = 3'b000;
               1: iw[13:11] = 3'b100;
               default: iw[13:11] = 3'b111;
            endcase
         end
         1, 2: iw[15:14] = 2'b11;
         default: ;
      endcase
      if (iw[15:14] == 2'b11 && iw[7:4] == 4'h7) iw[7:4] = 4'h6;
      if (iw[15:14] == 2'b11 && iw[7:4] == 4'hF && $urandom_range(0, 7) != 0) iw[7:4] = 4'h0;
      return iw;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      bit   h;
      obs_t e;
      zo = '0;
      rst = 1'b1; run = 1'b0; szcv = 4'h0;
`ifdef SIMPLE_CTRL_STEP_EN
      step = 1'b1;
`endif
      for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;

      tv[0]  = '{16'h8105, 3'd0, 3'd0, 3'd1, 8'b0010_0100, 4'h0, 8'h05, 1'b0}; // LI R1,5
      tv[1]  = '{16'hDA00, 3'd2, 3'd3, 3'd2, 8'b1111_0000, 4'h0, 8'h00, 1'b0}; // ADD R2,R3
      tv[2]  = '{16'hDA50, 3'd2, 3'd3, 3'd2, 8'b1101_0000, 4'h5, 8'h00, 1'b0}; // CMP R2,R3
      tv[3]  = '{16'hC483, 3'd0, 3'd4, 3'd4, 8'b0110_1000, 4'h8, 8'h03, 1'b0}; // SLL R4,3
      tv[4]  = '{16'hC5C0, 3'd0, 3'd0, 3'd5, 8'b0010_0010, 4'h0, 8'h00, 1'b0}; // IN R5
      tv[5]  = '{16'hF0D0, 3'd0, 3'd6, 3'd0, 8'b0100_0001, 4'h0, 8'h00, 1'b0}; // OUT R6
      tv[6]  = '{16'h0000, 3'd0, 3'd0, 3'd0, 8'b0000_0000, 4'h0, 8'h00, 1'b1}; // op1=00
      tv[7]  = '{16'hC070, 3'd0, 3'd0, 3'd0, 8'b0000_0000, 4'h0, 8'h00, 1'b1}; // op3=0111
      tv[8]  = '{16'hCF40, 3'd7, 3'd1, 3'd7, 8'b1111_0000, 4'h4, 8'h00, 1'b0}; // XOR R7,R1
      tv[9]  = '{16'h9000, 3'd0, 3'd0, 3'd0, 8'b0000_0000, 4'h0, 8'h00, 1'b1}; // op2=010
      tv[10] = '{16'hBC03, 3'd0, 3'd0, 3'd0, 8'b0000_0000, 4'h0, 8'h00, 1'b1}; // cond 100
      tv[11] = '{16'hC3BF, 3'd0, 3'd3, 3'd3, 8'b0110_1000, 4'hB, 8'h0F, 1'b0}; // SRA R3,15

      // Reset values, then IDLE holds without run.
      tick(); tick();
      check("rst_ctl", sample(), zo);
      check("rst_pc", pc, 16'h0);
      rst = 1'b0;
      tick(); tick(); tick();
      check("idle_ctl", sample(), zo);
      check("idle_pc", pc, 16'h0);

      // Constant vector table.
      for (int k = 0; k < NV; k++) mem[k] = tv[k].iw;
      reset_run();
      for (int k = 0; k < NV; k++) begin
         e = '0;
         e.ar = tv[k].ar; e.br = tv[k].br; e.wr = tv[k].wr;
         {e.rd_ar, e.rd_br, e.wr_en, e.alu, e.sft, e.immd_en, e.in_en} = tv[k].en[7:1];
         e.op3 = tv[k].op3; e.immd = tv[k].immd;
         check($sformatf("tv%0d_pc", k), pc, 16'(k));
         tick();
         check($sformatf("tv%0d_exec", k), sample(), e);
         tick();
         e.wrclk = 1'b1; e.out_en = tv[k].en[0]; e.illegal = tv[k].ill;
         check($sformatf("tv%0d_wb", k), sample(), e);
         tick();
         pause_pass();
      end
      check("tv_end_ctl", sample(), zo);

      // LI then HLT: halts with pc held at 1, run ignored in HALT.
      mem[0] = 16'h8105; mem[1] = 16'hC0F0;
      reset_run();
      run_instr(4'h0, h);
      run_instr(4'h0, h);
      check("hlt_halted", {31'h0, halted}, 32'h1);
      run = 1'b1;
      tick(); tick(); tick();
      run = 1'b0;
      check("hlt_pc_held", pc, 16'h1);
      check("hlt_still", {31'h0, halted}, 32'h1);

      // Conditional branch reads the latched flags, not live szcv.
      for (int a = 0; a < 4; a++) mem[a] = 16'h8000;
      mem[4] = 16'hDA50; mem[5] = 16'hB8FE; mem[6] = 16'hC0F0;
      reset_run();
      for (int a = 0; a < 4; a++) run_instr(4'h0, h);
      run_instr(4'b0100, h);
      run_instr(4'b0000, h);
      check("be_taken_pc", pc, 16'h0004);
      run_instr(4'b0000, h);
      run_instr(4'b1111, h);
      check("be_not_taken_pc", pc, 16'h0006);
      run_instr(4'h0, h);

      // PC wraps; illegal encoding retires as NOP.
      mem[16'h0000] = 16'hA080; mem[16'hFF81] = 16'hA06E; mem[16'hFFF0] = 16'hA07F;
      mem[16'h0070] = 16'h0000; mem[16'h0071] = 16'hC0F0;
      reset_run();
      run_instr(4'h0, h);
      check("b_neg_pc", pc, 16'hFF81);
      run_instr(4'h0, h);
      check("b_fff0_pc", pc, 16'hFFF0);
      run_instr(4'h0, h);
      check("b_wrap_pc", pc, 16'h0070);
      run_instr(4'h0, h);
      check("nop_pc", pc, 16'h0071);
      run_instr(4'h0, h);

      // Reset during WB of ADD abandons it and returns to IDLE.
      mem[0] = 16'hDA00;
      reset_run();
      tick(); tick();
      check("rwb_wrclk", {31'h0, wrclk}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rwb_ctl", sample(), zo);
      check("rwb_pc", pc, 16'h0);
      for (int a = 0; a < 3; a++) begin
         tick();
         check("rwb_idle", sample(), zo);
      end
      run = 1'b1;
      tick();
      run = 1'b0;
      check("rwb_fetch", sample(), zo);
      tick();
      check("rwb_exec", sample(), m_ctl(16'hDA00, 1));

`ifdef SIMPLE_CTRL_STEP_EN
      // Single-step: PAUSE holds until step.
      mem[0] = 16'hDA00; mem[1] = 16'hEC00;
      step = 1'b0;
      reset_run();
      tick(); tick(); tick();
      for (int a = 0; a < 10; a++) begin
         check("step_hold_ctl", sample(), zo);
         check("step_hold_pc", pc, 16'h1);
         tick();
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_fetch_ctl", sample(), zo);
      tick();
      check("step_exec", sample(), m_ctl(16'hEC00, 1));
      step = 1'b1;
`endif

      // Random programs generated at fetch time.
      reset_run();
      for (int n = 0; n < 400; n++) begin
         mem[m_pc] = gen_instr();
         run_instr(4'($urandom), h);
         if (h) reset_run();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
